// File: rtl/glb_dma_header_queue_if.sv
// glb_dma_header_queue_if: header push/issue bus; GLB_HDR_QUEUE_STAT_EN adds stat_clr/ovf_err/zero_err
interface glb_dma_header_queue_if #(
    parameter int QUEUE_DEPTH         = 4,
    parameter int GLB_ADDR_WIDTH      = 22,
    parameter int MAX_NUM_WORDS_WIDTH = 21
);
    localparam int CNT_WIDTH = $clog2(QUEUE_DEPTH + 1);
    logic                           push_valid;
    logic                           push_ready;
    logic [GLB_ADDR_WIDTH-1:0]      push_start_addr;
    logic [MAX_NUM_WORDS_WIDTH-1:0] push_num_words;
    logic                           push_is_repeat;
    logic                           flush;
    logic                           hdr_valid;
    logic                           hdr_ready;
    logic [GLB_ADDR_WIDTH-1:0]      hdr_start_addr;
    logic [MAX_NUM_WORDS_WIDTH-1:0] hdr_num_words;
    logic                           hdr_is_repeat;
    logic [CNT_WIDTH-1:0]           count;
`ifdef GLB_HDR_QUEUE_STAT_EN
    logic                           stat_clr;
    logic                           ovf_err;
    logic                           zero_err;
    modport master (
        output push_valid, push_start_addr, push_num_words, push_is_repeat, flush, hdr_ready, stat_clr,
        input  push_ready, hdr_valid, hdr_start_addr, hdr_num_words, hdr_is_repeat, count, ovf_err, zero_err
    );
    modport slave (
        input  push_valid, push_start_addr, push_num_words, push_is_repeat, flush, hdr_ready, stat_clr,
        output push_ready, hdr_valid, hdr_start_addr, hdr_num_words, hdr_is_repeat, count, ovf_err, zero_err
    );
`else
    modport master (
        output push_valid, push_start_addr, push_num_words, push_is_repeat, flush, hdr_ready,
        input  push_ready, hdr_valid, hdr_start_addr, hdr_num_words, hdr_is_repeat, count
    );
    modport slave (
        input  push_valid, push_start_addr, push_num_words, push_is_repeat, flush, hdr_ready,
        output push_ready, hdr_valid, hdr_start_addr, hdr_num_words, hdr_is_repeat, count
    );
`endif
endinterface

// File: rtl/glb_dma_header_queue.sv
// glb_dma_header_queue: FWFT DMA header FIFO with repeat recycling; GLB_HDR_QUEUE_STAT_EN adds sticky error flags
module glb_dma_header_queue #(
    parameter int QUEUE_DEPTH         = 4,
    parameter int GLB_ADDR_WIDTH      = 22,
    parameter int MAX_NUM_WORDS_WIDTH = 21
) (
    input logic                   clk,
    input logic                   reset,
    glb_dma_header_queue_if.slave q
);
    localparam int CNT_WIDTH = $clog2(QUEUE_DEPTH + 1);
    localparam int EW        = GLB_ADDR_WIDTH + MAX_NUM_WORDS_WIDTH + 1;
    localparam int PW        = QUEUE_DEPTH > 1 ? $clog2(QUEUE_DEPTH) : 1;
    typedef logic [PW-1:0] ptr_t;

    function automatic ptr_t inc(input ptr_t p);
        return (p == PW'(QUEUE_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    logic [EW-1:0]        r_mem [QUEUE_DEPTH];
    ptr_t                 r_wr_ptr, r_rd_ptr;
    logic [CNT_WIDTH-1:0] r_count;
    logic [EW-1:0]        w_head, w_push_ent;
    logic                 w_valid, w_ready, w_push, w_pop, w_rec;

    assign w_valid    = r_count != '0;
    assign w_ready    = r_count < CNT_WIDTH'(QUEUE_DEPTH);
    assign w_head     = r_mem[r_rd_ptr];
    assign w_push_ent = {q.push_start_addr, q.push_num_words, q.push_is_repeat};
    assign w_push     = q.push_valid & w_ready & (q.push_num_words != '0);
    assign w_pop      = w_valid & q.hdr_ready;
    assign w_rec      = w_pop & w_head[0];

    assign q.push_ready = w_ready;
    assign q.hdr_valid  = w_valid;
    assign q.count      = r_count;
    assign {q.hdr_start_addr, q.hdr_num_words, q.hdr_is_repeat} = w_valid ? w_head : '0;

    // Storage is never cleared; count=0 masks stale entries after flush/reset.
    always_ff @(posedge clk) begin
        if (!reset && !q.flush) begin
            if (w_rec) r_mem[r_wr_ptr] <= w_head;
            if (w_push) r_mem[w_rec ? inc(r_wr_ptr) : r_wr_ptr] <= w_push_ent;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || q.flush) begin
            r_count  <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            r_count  <= r_count + CNT_WIDTH'(w_push) - CNT_WIDTH'(w_pop) + CNT_WIDTH'(w_rec);
            r_rd_ptr <= w_pop ? inc(r_rd_ptr) : r_rd_ptr;
            r_wr_ptr <= (w_rec && w_push) ? inc(inc(r_wr_ptr)) : (w_rec || w_push) ? inc(r_wr_ptr) : r_wr_ptr;
        end
    end

`ifdef GLB_HDR_QUEUE_STAT_EN
    logic r_ovf_err, r_zero_err;
    assign q.ovf_err  = r_ovf_err;
    assign q.zero_err = r_zero_err;
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ovf_err  <= 1'b0;
            r_zero_err <= 1'b0;
        end else begin
            r_ovf_err  <= (q.push_valid & ~w_ready) | (r_ovf_err & ~q.stat_clr);
            r_zero_err <= (q.push_valid & w_ready & (q.push_num_words == '0)) | (r_zero_err & ~q.stat_clr);
        end
    end
`endif
endmodule

// File: tb/tb_glb_dma_header_queue.sv
// tb_glb_dma_header_queue: directed stimulus with scoreboard-checked header issue order
module tb_glb_dma_header_queue;
    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;
    logic [43:0] exp_q [$];

    always #5 clk = ~clk;

    glb_dma_header_queue_if #(.QUEUE_DEPTH(4), .GLB_ADDR_WIDTH(22), .MAX_NUM_WORDS_WIDTH(21)) bus ();
    glb_dma_header_queue #(.QUEUE_DEPTH(4), .GLB_ADDR_WIDTH(22), .MAX_NUM_WORDS_WIDTH(21)) dut (
        .clk(clk), .reset(reset), .q(bus)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [43:0] hdr(input logic [21:0] a, input logic [20:0] n, input logic r);
        return {a, n, r};
    endfunction

    task automatic push_hdr(input logic [21:0] a, input logic [20:0] n, input logic r);
        bus.push_valid      = 1'b1;
        bus.push_start_addr = a;
        bus.push_num_words  = n;
        bus.push_is_repeat  = r;
        @(posedge clk);
        #1 bus.push_valid = 1'b0;
    endtask

    task automatic pulse_flush();
        bus.flush = 1'b1;
        @(posedge clk);
        #1 bus.flush = 1'b0;
    endtask

    always @(negedge clk) begin
        if (bus.hdr_valid && bus.hdr_ready) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL issue: unexpected header %0h", {bus.hdr_start_addr, bus.hdr_num_words, bus.hdr_is_repeat});
            end else begin
                logic [43:0] e;
                e = exp_q.pop_front();
                if ({bus.hdr_start_addr, bus.hdr_num_words, bus.hdr_is_repeat} !== e) begin
                    bad++;
                    $display("FAIL issue: got %0h expected %0h", {bus.hdr_start_addr, bus.hdr_num_words, bus.hdr_is_repeat}, e);
                end
            end
        end
    end

    initial begin
        reset = 1'b1;
        bus.push_valid = 1'b0; bus.push_start_addr = '0; bus.push_num_words = '0; bus.push_is_repeat = 1'b0;
        bus.flush = 1'b0; bus.hdr_ready = 1'b0;
`ifdef GLB_HDR_QUEUE_STAT_EN
        bus.stat_clr = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        chk("rst_count", 64'(bus.count), 0);
        chk("rst_valid", 64'(bus.hdr_valid), 0);
        chk("rst_ready", 64'(bus.push_ready), 1);
        chk("rst_addr", 64'(bus.hdr_start_addr), 0);
`ifdef GLB_HDR_QUEUE_STAT_EN
        chk("rst_ovf", 64'(bus.ovf_err), 0);
        chk("rst_zero", 64'(bus.zero_err), 0);
`endif

        // A then B stream straight through
        bus.hdr_ready = 1'b1;
        exp_q.push_back(hdr(22'h100, 21'd8, 1'b0));
        exp_q.push_back(hdr(22'h200, 21'd4, 1'b0));
        push_hdr(22'h100, 21'd8, 1'b0);
        chk("ab_count1", 64'(bus.count), 1);
        push_hdr(22'h200, 21'd4, 1'b0);
        @(posedge clk);
        #1 chk("ab_count0", 64'(bus.count), 0);
        chk("ab_valid0", 64'(bus.hdr_valid), 0);
        bus.hdr_ready = 1'b0;

        // fill, then a 5th offer coinciding with a pop is still refused
        push_hdr(22'h011, 21'd1, 1'b0);
        push_hdr(22'h022, 21'd2, 1'b0);
        push_hdr(22'h033, 21'd3, 1'b0);
        push_hdr(22'h044, 21'd4, 1'b0);
        chk("full_count", 64'(bus.count), 4);
        chk("full_ready", 64'(bus.push_ready), 0);
        chk("full_head", 64'(bus.hdr_start_addr), 64'h011);
        exp_q.push_back(hdr(22'h011, 21'd1, 1'b0));
        exp_q.push_back(hdr(22'h022, 21'd2, 1'b0));
        exp_q.push_back(hdr(22'h033, 21'd3, 1'b0));
        exp_q.push_back(hdr(22'h044, 21'd4, 1'b0));
        bus.hdr_ready = 1'b1;
        push_hdr(22'h055, 21'd5, 1'b0);
        chk("ovf_count", 64'(bus.count), 3);
`ifdef GLB_HDR_QUEUE_STAT_EN
        chk("ovf_err", 64'(bus.ovf_err), 1);
`endif
        repeat (3) @(posedge clk);
        #1 bus.hdr_ready = 1'b0;
        chk("ovf_drain", 64'(bus.count), 0);

        // single repeat header issues every cycle
        push_hdr(22'h040, 21'd2, 1'b1);
        for (int i = 0; i < 5; i++) exp_q.push_back(hdr(22'h040, 21'd2, 1'b1));
        bus.hdr_ready = 1'b1;
        repeat (5) @(posedge clk);
        #1 bus.hdr_ready = 1'b0;
        chk("rep_count", 64'(bus.count), 1);
        chk("rep_head", 64'(bus.hdr_is_repeat), 1);
        pulse_flush();
        chk("rep_flush", 64'(bus.count), 0);

        // recycle and push in the same cycle: order X, R, Y
        push_hdr(22'h300, 21'd3, 1'b1);
        push_hdr(22'h400, 21'd5, 1'b0);
        exp_q.push_back(hdr(22'h300, 21'd3, 1'b1));
        bus.hdr_ready = 1'b1;
        push_hdr(22'h500, 21'd6, 1'b0);
        bus.hdr_ready = 1'b0;
        chk("rp_count", 64'(bus.count), 3);
        chk("rp_head", 64'(bus.hdr_start_addr), 64'h400);
        exp_q.push_back(hdr(22'h400, 21'd5, 1'b0));
        exp_q.push_back(hdr(22'h300, 21'd3, 1'b1));
        exp_q.push_back(hdr(22'h500, 21'd6, 1'b0));
        bus.hdr_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 bus.hdr_ready = 1'b0;
        chk("rp_left", 64'(bus.count), 1);
        chk("rp_left_addr", 64'(bus.hdr_start_addr), 64'h300);
        pulse_flush();

        // zero-length offer is dropped
        push_hdr(22'h600, 21'd0, 1'b0);
        chk("zero_count", 64'(bus.count), 0);
        chk("zero_valid", 64'(bus.hdr_valid), 0);
        chk("zero_ready", 64'(bus.push_ready), 1);
`ifdef GLB_HDR_QUEUE_STAT_EN
        chk("zero_err", 64'(bus.zero_err), 1);
        bus.stat_clr = 1'b1;
        @(posedge clk);
        #1 bus.stat_clr = 1'b0;
        chk("zero_clr", 64'(bus.zero_err), 0);
        chk("ovf_clr", 64'(bus.ovf_err), 0);
`endif

        // flush beats simultaneous pop and push
        push_hdr(22'h701, 21'd1, 1'b1);
        push_hdr(22'h702, 21'd2, 1'b0);
        push_hdr(22'h703, 21'd3, 1'b0);
        chk("fl_fill", 64'(bus.count), 3);
        exp_q.push_back(hdr(22'h701, 21'd1, 1'b1));
        bus.flush = 1'b1;
        bus.hdr_ready = 1'b1;
        push_hdr(22'h704, 21'd4, 1'b0);
        bus.flush = 1'b0;
        bus.hdr_ready = 1'b0;
        chk("fl_count", 64'(bus.count), 0);
        chk("fl_valid", 64'(bus.hdr_valid), 0);
        chk("fl_addr", 64'(bus.hdr_start_addr), 0);
        @(posedge clk);
        #1 chk("fl_stay", 64'(bus.count), 0);

        // reset mid-operation behaves like flush
        push_hdr(22'h801, 21'd1, 1'b0);
        push_hdr(22'h802, 21'd2, 1'b0);
        push_hdr(22'h803, 21'd3, 1'b0);
        reset = 1'b1;
        push_hdr(22'h804, 21'd4, 1'b0);
        reset = 1'b0;
        chk("rs_count", 64'(bus.count), 0);
        chk("rs_valid", 64'(bus.hdr_valid), 0);
        push_hdr(22'h900, 21'd9, 1'b0);
        chk("rs_after", 64'(bus.hdr_start_addr), 64'h900);
        pulse_flush();

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
        chk("drain", 64'(exp_q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
